// File: rtl/iram_loader_if.sv
// Byte-stream, status and IRAM write-port signals of the IRAM loader.
// The loader takes the slave view; the UART/IRAM/reset side takes the master view.
interface iram_loader_if #(
  parameter int unsigned AW = 13
) ();
  logic [7:0]    rx_data_i;
  logic          rx_valid_i;
  logic          rx_ready_o;
  logic [7:0]    tx_data_o;
  logic          tx_valid_o;
  logic          tx_ready_i;
  logic          iram_we_o;
  logic [AW-1:0] iram_addr_o;
  logic [31:0]   iram_wdata_o;
  logic          core_rst_o;
  logic          busy_o;
  logic          err_o;

  modport slave (
    input  rx_data_i, rx_valid_i, tx_ready_i,
    output rx_ready_o, tx_data_o, tx_valid_o, iram_we_o, iram_addr_o, iram_wdata_o,
           core_rst_o, busy_o, err_o
  );

  modport master (
    output rx_data_i, rx_valid_i, tx_ready_i,
    input  rx_ready_o, tx_data_o, tx_valid_o, iram_we_o, iram_addr_o, iram_wdata_o,
           core_rst_o, busy_o, err_o
  );
endinterface

// File: rtl/iram_loader.sv
// Loads IRAM from a framed UART byte stream and holds the core in reset meanwhile.
// Define LOADER_CKSUM_EN to make a checksum mismatch fail the frame.
module iram_loader #(
  parameter int unsigned AW  = 13,
  parameter int unsigned TMO = 100000
) (
  input  logic         clk,
  input  logic         rst,
  iram_loader_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StAddr, StCnt, StData, StCksum, StResp} state_e;

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [31:0]   addr_q, addr_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   rem_q, rem_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [31:0]   word_q, word_d;
  logic [7:0]    sum_q, sum_d;
  logic          err_q, err_d;
  logic          core_rst_q, core_rst_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   tmo_q, tmo_d;

  logic        accept;
  logic        timed;
  logic [31:0] addr_sh;
  logic [15:0] cnt_sh;
  logic [31:0] range_end;

  assign accept    = bus.rx_valid_i && (state_q != StResp);
  assign timed     = (state_q != StIdle) && (state_q != StResp);
  assign addr_sh   = {bus.rx_data_i, addr_q[31:8]};
  assign cnt_sh    = {bus.rx_data_i, cnt_q[15:8]};
  assign range_end = 32'(ptr_q) + 32'(cnt_sh);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    ptr_d      = ptr_q;
    word_d     = word_q;
    sum_d      = sum_q;
    err_d      = err_q;
    core_rst_d = core_rst_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    tmo_d      = 32'd0;

    if (TMO != 0 && timed && !accept) tmo_d = tmo_q + 32'd1;

    unique case (state_q)
      StIdle: begin
        if (accept && bus.rx_data_i == 8'hA5) begin
          state_d    = StAddr;
          idx_d      = 2'd0;
          sum_d      = 8'd0;
          err_d      = 1'b0;
          core_rst_d = 1'b1;
        end
      end
      StAddr: begin
        if (accept) begin
          addr_d = addr_sh;
          sum_d  = sum_q + bus.rx_data_i;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            ptr_d   = addr_sh[AW+1:2];
            state_d = StCnt;
            if (addr_sh[1:0] != 2'd0 || (addr_sh >> (AW + 2)) != 32'd0) err_d = 1'b1;
          end
        end
      end
      StCnt: begin
        if (accept) begin
          cnt_d = cnt_sh;
          sum_d = sum_q + bus.rx_data_i;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd1) begin
            idx_d   = 2'd0;
            rem_d   = cnt_sh;
            state_d = (cnt_sh == 16'd0) ? StCksum : StData;
            if (range_end > (32'd1 << AW)) err_d = 1'b1;
          end
        end
      end
      StData: begin
        if (accept) begin
          word_d[8*idx_q +: 8] = bus.rx_data_i;
          sum_d                = sum_q + bus.rx_data_i;
          idx_d                = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            // Write lands the cycle after the last lane; the next byte is accepted meanwhile.
            we_d    = !err_q;
            waddr_d = ptr_q;
            wdata_d = {bus.rx_data_i, word_q[23:0]};
            ptr_d   = ptr_q + 1'b1;
            rem_d   = rem_q - 16'd1;
            if (rem_q == 16'd1) state_d = StCksum;
          end
        end
      end
      StCksum: begin
        if (accept) begin
`ifdef LOADER_CKSUM_EN
          if (bus.rx_data_i != sum_q) err_d = 1'b1;
`endif
          state_d = StResp;
        end
      end
      StResp: begin
        if (bus.tx_ready_i) begin
          state_d = StIdle;
          if (!err_q) core_rst_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (TMO != 0 && timed && !accept && tmo_q == TMO - 1) begin
      err_d   = 1'b1;
      state_d = StResp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      rem_q      <= '0;
      ptr_q      <= '0;
      word_q     <= '0;
      sum_q      <= '0;
      err_q      <= 1'b0;
      core_rst_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      ptr_q      <= ptr_d;
      word_q     <= word_d;
      sum_q      <= sum_d;
      err_q      <= err_d;
      core_rst_q <= core_rst_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      tmo_q      <= tmo_d;
    end
  end

  assign bus.rx_ready_o   = (state_q != StResp);
  assign bus.tx_valid_o   = (state_q == StResp);
  assign bus.tx_data_o    = (state_q != StResp) ? 8'h00 : (err_q ? 8'hEE : 8'h5A);
  assign bus.iram_we_o    = we_q;
  assign bus.iram_addr_o  = waddr_q;
  assign bus.iram_wdata_o = wdata_q;
  assign bus.core_rst_o   = core_rst_q;
  assign bus.busy_o       = (state_q != StIdle);
  assign bus.err_o        = err_q;

endmodule

// File: tb/tb_iram_loader.sv
// Scoreboard bench for iram_loader: directed frames push expected writes and status
// bytes; a negedge monitor pops and compares whatever the loader presents.
module tb_iram_loader;
  localparam int unsigned AW  = 13;
  localparam int unsigned TMO = 40;
`ifdef LOADER_CKSUM_EN
  localparam bit CkEn = 1'b1;
`else
  localparam bit CkEn = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  wr_t        exp_wr[$];
  logic [7:0] exp_tx[$];
  logic [7:0] frame[$];

  iram_loader_if #(.AW(AW)) bus ();

  iram_loader #(.AW(AW), .TMO(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every write strobe and every status handshake.
  initial begin
    wr_t        e;
    logic [7:0] t;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.iram_we_o) begin
          if (exp_wr.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write",
                     bus.iram_addr_o, bus.iram_wdata_o);
          end else begin
            e = exp_wr.pop_front();
            check("wr_addr", 32'(bus.iram_addr_o), e.addr);
            check("wr_data", bus.iram_wdata_o, e.data);
          end
        end
        if (bus.tx_valid_o && bus.tx_ready_i) begin
          if (exp_tx.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_tx: got %h expected no status byte", bus.tx_data_o);
          end else begin
            t = exp_tx.pop_front();
            check("tx_data", 32'(bus.tx_data_o), 32'(t));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Called at #1 after a rising edge; returns at #1 after the edge that took the byte.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.rx_data_i  = b;
    bus.rx_valid_i = 1'b1;
    while (!bus.rx_ready_o && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n == 100) begin
      n_chk++;
      n_fail++;
      $display("FAIL rx_ready_wait: got stuck low expected high");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame();
    foreach (frame[i]) send_byte(frame[i]);
    bus.rx_valid_i = 1'b0;
  endtask

  task automatic wait_resp(input logic exp_err, input logic exp_crst);
    int n = 0;
    while (!(bus.tx_valid_o && bus.tx_ready_i) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n == 300) begin
      n_chk++;
      n_fail++;
      $display("FAIL resp_wait: got no status handshake expected one");
    end
    @(posedge clk);
    #1;
    check("busy_after", 32'(bus.busy_o), 32'(0));
    check("err_after", 32'(bus.err_o), 32'(exp_err));
    check("core_rst_after", 32'(bus.core_rst_o), 32'(exp_crst));
    check("tx_valid_after", 32'(bus.tx_valid_o), 32'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, 32'(bus.rx_ready_o), 32'(1));
    check({tag, "_tx_valid"}, 32'(bus.tx_valid_o), 32'(0));
    check({tag, "_tx_data"}, 32'(bus.tx_data_o), 32'(0));
    check({tag, "_we"}, 32'(bus.iram_we_o), 32'(0));
    check({tag, "_addr"}, 32'(bus.iram_addr_o), 32'(0));
    check({tag, "_wdata"}, bus.iram_wdata_o, 32'(0));
    check({tag, "_core_rst"}, 32'(bus.core_rst_o), 32'(0));
    check({tag, "_busy"}, 32'(bus.busy_o), 32'(0));
    check({tag, "_err"}, 32'(bus.err_o), 32'(0));
  endtask

  task automatic frame_a(input logic [7:0] cksum);
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00,
              8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, cksum};
    exp_wr.push_back('{32'd0, 32'h0000_0013});
    exp_wr.push_back('{32'd1, 32'h0000_006F});
  endtask

  initial begin
    bus.rx_data_i  = 8'h00;
    bus.rx_valid_i = 1'b0;
    bus.tx_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("reset");

    // Basic two-word load with correct checksum (2+0x13+0x6F = 0x84).
    send_byte(8'hA5);
    check("sync_busy", 32'(bus.busy_o), 32'(1));
    check("sync_core_rst", 32'(bus.core_rst_o), 32'(1));
    frame_a(8'h84);
    void'(frame.pop_front());
    exp_tx.push_back(8'h5A);
    send_frame();
    wait_resp(1'b0, 1'b0);

    // Same frame with a bad checksum; data still written.
    frame_a(8'h85);
    exp_tx.push_back(CkEn ? 8'hEE : 8'h5A);
    send_frame();
    wait_resp(CkEn, CkEn);

    // Garbage before a one-word frame at byte address 0x10.
    frame = '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00,
              8'h78, 8'h56, 8'h34, 8'h12, 8'h25};
    exp_wr.push_back('{32'd4, 32'h1234_5678});
    exp_tx.push_back(8'h5A);
    send_frame();
    wait_resp(1'b0, 1'b0);

    // Misaligned byte address: data consumed, nothing written.
    frame = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00,
              8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11};
    exp_tx.push_back(8'hEE);
    send_frame();
    wait_resp(1'b1, 1'b1);

    // Range overrun: last word of IRAM with CNT=2.
    frame = '{8'hA5, 8'hFC, 8'h7F, 8'h00, 8'h00, 8'h02, 8'h00,
              8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hA1};
    exp_tx.push_back(8'hEE);
    send_frame();
    wait_resp(1'b1, 1'b1);

    // Empty frame.
    frame = '{8'hA5, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20};
    exp_tx.push_back(8'h5A);
    send_frame();
    wait_resp(1'b0, 1'b0);

    // Empty frame with the transmitter stalled for 20 cycles.
    frame = '{8'hA5, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_tx.push_back(8'h5A);
    send_frame();
    bus.tx_ready_i = 1'b0;
    send_byte(8'h20);
    bus.rx_valid_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check("stall_tx_valid", 32'(bus.tx_valid_o), 32'(1));
      check("stall_tx_data", 32'(bus.tx_data_o), 32'(8'h5A));
      check("stall_rx_ready", 32'(bus.rx_ready_o), 32'(0));
      @(posedge clk);
      #1;
    end
    bus.tx_ready_i = 1'b1;
    wait_resp(1'b0, 1'b0);

    // Stall after three data bytes until the inter-byte timeout fires.
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33};
    exp_tx.push_back(8'hEE);
    send_frame();
    wait_resp(1'b1, 1'b1);

    // Reset on the edge that would complete a word: no strobe may follow.
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33};
    send_frame();
    bus.rx_data_i  = 8'h44;
    bus.rx_valid_i = 1'b1;
    rst            = 1'b1;
    @(posedge clk);
    #1;
    rst            = 1'b0;
    bus.rx_valid_i = 1'b0;
    check_reset_outputs("midrst");
    repeat (3) @(posedge clk);
    #1;

    // Full load after the abandoned frame.
    frame_a(8'h84);
    exp_tx.push_back(8'h5A);
    send_frame();
    wait_resp(1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("wr_queue_empty", 32'(exp_wr.size()), 32'(0));
    check("tx_queue_empty", 32'(exp_tx.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
